// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared types and sign-magnitude helpers for the fixed-point accumulator
package fxp_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int SM_MAX_W = 32;

    // True when an n-bit sign-magnitude word is the negative-zero pattern.
    function automatic logic sm_is_neg_zero(input logic [SM_MAX_W-1:0] word, input int n);
        logic [SM_MAX_W-1:0] mag_mask;
        mag_mask = (SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1);
        return word[n-1] && ((word & mag_mask) == '0);
    endfunction

    // Reduce a wide magnitude to n-1 bits: clamp, or keep the low bits when wrapping.
    function automatic logic [SM_MAX_W-1:0] sm_sat(input logic [SM_MAX_W-1:0] mag,
                                                   input int n, input logic saturate);
        logic [SM_MAX_W-1:0] lim;
        lim = (SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1);
        if (mag <= lim) begin
            return mag;
        end
        return saturate ? lim : (mag & lim);
    endfunction

endpackage

// File: rtl/fix_point_accum_sm_add.sv
// rtl/fix_point_accum_sm_add.sv - combinational sign-magnitude adder with carry-out
module sm_add #(
    parameter int W = 19
) (
    input  logic         a_sign,
    input  logic [W-1:0] a_mag,
    input  logic         b_sign,
    input  logic [W-1:0] b_mag,
    output logic         s_sign,
    output logic [W-1:0] s_mag,
    output logic         carry
);

    logic         a_neg;
    logic         b_neg;
    logic [W:0]   mag_sum;

    always_comb begin
        a_neg   = a_sign && (a_mag != '0);
        b_neg   = b_sign && (b_mag != '0);
        mag_sum = {1'b0, a_mag} + {1'b0, b_mag};
        s_sign  = 1'b0;
        s_mag   = '0;
        carry   = 1'b0;
        if (a_neg == b_neg) begin
            {carry, s_mag} = mag_sum;
            s_sign         = a_neg;
        end else if (a_mag >= b_mag) begin
            s_mag  = a_mag - b_mag;
            s_sign = a_neg;
        end else begin
            s_mag  = b_mag - a_mag;
            s_sign = b_neg;
        end
        if (s_mag == '0) begin
            s_sign = 1'b0;
        end
    end

endmodule

// File: rtl/fix_point_accum.sv
// rtl/fix_point_accum.sv - streaming sign-magnitude accumulator with guard bits and output saturation
module fix_point_accum
    import fxp_pkg::*;
#(
    parameter int N        = 16,
    parameter int Q        = 13,
    parameter int GUARD    = 4,
    parameter int MAX_LEN  = 64,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_trunc
);

    localparam int AW      = N - 1 + GUARD;
    localparam int MW      = N - 1;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int MAX_MAG = (1 << (N - 1)) - 1;

    if (Q < 0 || Q > N - 1) begin : g_q_range
        $error("fix_point_accum: Q must lie in 0..N-1");
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_mag_q, acc_mag_d;
    logic            acc_sign_q, acc_sign_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            sticky_q, sticky_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_ovf_q, out_ovf_d;
    logic            out_trunc_q, out_trunc_d;

    logic            in_sign;
    logic [AW-1:0]   in_mag;
    logic            add_sign;
    logic [AW-1:0]   add_mag;
    logic            add_carry;
    logic [AW-1:0]   nxt_mag;
    logic            nxt_sticky;
    logic            beat_acc;
    logic            at_max;
    logic            frame_end;
    logic [MW-1:0]   res_mag;
    logic            res_ovf;

    assign in_sign = in_data[N-1] && !sm_is_neg_zero(SM_MAX_W'(in_data), N);
    assign in_mag  = AW'(in_data[N-2:0]);

    sm_add #(.W(AW)) u_add (
        .a_sign (acc_sign_q),
        .a_mag  (acc_mag_q),
        .b_sign (in_sign),
        .b_mag  (in_mag),
        .s_sign (add_sign),
        .s_mag  (add_mag),
        .carry  (add_carry)
    );

    // A carry out of the guard width pins the accumulator at full scale.
    assign nxt_mag    = add_carry ? '1 : add_mag;
    assign nxt_sticky = sticky_q | add_carry;
    assign beat_acc   = in_valid && (state_q == ACCUM);
    assign at_max     = (beat_cnt_q == CW'(MAX_LEN - 1));
    assign frame_end  = beat_acc && (in_last || at_max);
    assign res_mag    = MW'(sm_sat(SM_MAX_W'(nxt_mag), N, SATURATE != 0));
    assign res_ovf    = nxt_sticky || (nxt_mag > AW'(MAX_MAG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (frame_end) state_d = DONE;
            DONE:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        acc_mag_d   = acc_mag_q;
        acc_sign_d  = acc_sign_q;
        beat_cnt_d  = beat_cnt_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;
        if (beat_acc) begin
            acc_mag_d  = nxt_mag;
            acc_sign_d = add_sign;
            beat_cnt_d = beat_cnt_q + CW'(1);
            sticky_d   = nxt_sticky;
            if (frame_end) begin
                out_data_d  = {add_sign && (res_mag != '0), res_mag};
                out_ovf_d   = res_ovf;
                out_trunc_d = at_max && !in_last;
            end
        end else if ((state_q == DONE) && out_ready) begin
            acc_mag_d   = '0;
            acc_sign_d  = 1'b0;
            beat_cnt_d  = '0;
            sticky_d    = 1'b0;
            out_data_d  = '0;
            out_ovf_d   = 1'b0;
            out_trunc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_mag_q   <= '0;
            acc_sign_q  <= 1'b0;
            beat_cnt_q  <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            acc_mag_q   <= acc_mag_d;
            acc_sign_q  <= acc_sign_d;
            beat_cnt_q  <= beat_cnt_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_fix_point_accum.sv
// tb/tb_fix_point_accum.sv - scoreboard bench for fix_point_accum across three parameter sets
module tb_fix_point_accum;

    localparam int NDUT = 3;
    localparam int SAT_P  [NDUT] = '{1, 0, 1};
    localparam int MAXL_P [NDUT] = '{64, 64, 4};
    localparam int MAXG = (1 << 19) - 1;

    typedef struct {
        int          dut;
        logic [15:0] data;
        logic        ovf;
        logic        trunc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_v [NDUT];
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready_w  [NDUT];
    logic        out_valid_w [NDUT];
    logic [15:0] out_data_w  [NDUT];
    logic        out_ovf_w   [NDUT];
    logic        out_trunc_w [NDUT];

    int m_acc    [NDUT];
    bit m_sticky [NDUT];
    int m_cnt    [NDUT];

    always #5 clk = ~clk;

    fix_point_accum #(.SATURATE(1), .MAX_LEN(64)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(out_data_w[0]), .out_ovf(out_ovf_w[0]), .out_trunc(out_trunc_w[0]));
    fix_point_accum #(.SATURATE(0), .MAX_LEN(64)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(out_data_w[1]), .out_ovf(out_ovf_w[1]), .out_trunc(out_trunc_w[1]));
    fix_point_accum #(.SATURATE(1), .MAX_LEN(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .out_data(out_data_w[2]), .out_ovf(out_ovf_w[2]), .out_trunc(out_trunc_w[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_acc[k] = 0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    // Exact signed sum with the guard range clamp; output rules applied on frame end.
    task automatic model_beat(input int k, input logic [15:0] d, input logic last, output bit ended);
        int   x;
        int   mag;
        exp_t e;
        x = int'(d[14:0]);
        if (d[15]) x = -x;
        m_acc[k] = m_acc[k] + x;
        if (m_acc[k] > MAXG) begin
            m_acc[k] = MAXG; m_sticky[k] = 1'b1;
        end else if (m_acc[k] < -MAXG) begin
            m_acc[k] = -MAXG; m_sticky[k] = 1'b1;
        end
        m_cnt[k]++;
        ended = last || (m_cnt[k] == MAXL_P[k]);
        if (ended) begin
            mag   = (m_acc[k] < 0) ? -m_acc[k] : m_acc[k];
            e.ovf = m_sticky[k];
            if (mag > 32767) begin
                e.ovf = 1'b1;
                mag   = (SAT_P[k] != 0) ? 32767 : (mag % 32768);
            end
            e.data  = {(m_acc[k] < 0) && (mag != 0), mag[14:0]};
            e.trunc = !last && (m_cnt[k] == MAXL_P[k]);
            e.dut   = k;
            sb_q.push_back(e);
            m_acc[k] = 0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic send(input int k, input logic [15:0] d, input logic last, input bit rand_rdy);
        int budget;
        bit ended;
        @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        in_data = d;
        in_last = last;
        in_valid_v[k] = 1'b1;
        budget = 0;
        while (!in_ready_w[k] && budget < 100) begin
            @(negedge clk);
            out_ready = 1'b1;
            budget++;
        end
        if (!in_ready_w[k]) begin
            check("in_ready_timeout", 32'(in_ready_w[k]), 32'd1);
            in_valid_v[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        in_last = 1'b0;
        model_beat(k, d, last, ended);
        if (ended) begin
            @(negedge clk);
            check("latency_out_valid", 32'(out_valid_w[k]), 32'd1);
            check("done_in_ready_low", 32'(in_ready_w[k]), 32'd0);
        end
    endtask

    task automatic drain();
        int budget;
        @(negedge clk);
        out_ready = 1'b1;
        budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks idle outputs otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int k = 0; k < NDUT; k++) begin
                    if (out_valid_w[k] && out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("sb_unexpected_output", 32'(out_valid_w[k]), 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_dut", 32'(k), 32'(e.dut));
                            check("sb_result", {14'd0, out_ovf_w[k], out_trunc_w[k], out_data_w[k]},
                                  {14'd0, e.ovf, e.trunc, e.data});
                        end
                    end else if (!out_valid_w[k]) begin
                        check("idle_outputs_zero",
                              {14'd0, out_ovf_w[k], out_trunc_w[k], out_data_w[k]}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        int          len;
        int          k;
        logic [15:0] d;
        logic        last;
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("reset_in_ready", 32'(in_ready_w[i]), 32'd1);
            check("reset_out_valid", 32'(out_valid_w[i]), 32'd0);
        end
        rst = 1'b0;

        send(0, 16'h3000, 1'b0, 1'b0);
        send(0, 16'h0800, 1'b0, 1'b0);
        send(0, 16'h9800, 1'b1, 1'b0);
        send(0, 16'h1000, 1'b0, 1'b0);
        send(0, 16'h9000, 1'b1, 1'b0);
        send(0, 16'h8000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 16'h6000, i == 4, 1'b0);
        send(0, 16'h6000, 1'b0, 1'b0);
        send(0, 16'h6000, 1'b0, 1'b0);
        send(0, 16'hE000, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 5; i++) send(1, 16'h6000, i == 4, 1'b0);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2, 16'h0400, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("maxlen_in_ready_low", 32'(in_ready_w[2]), 32'd0);
            check("maxlen_hold_result", {15'd0, out_trunc_w[2], out_data_w[2]}, {15'd0, 1'b1, 16'h1000});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(2, 16'h0400, 1'b0, 1'b0);
        drain();

        out_ready = 1'b0;
        send(0, 16'h2345, 1'b0, 1'b0);
        send(0, 16'h8111, 1'b1, 1'b0);
        held = out_data_w[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data_stable", 32'(out_data_w[0]), 32'(held));
            check("bp_in_ready_low", 32'(in_ready_w[0]), 32'd0);
        end
        drain();

        send(0, 16'h1234, 1'b0, 1'b0);
        send(0, 16'h0111, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready_w[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send(0, 16'h0400, 1'b1, 1'b0);
        drain();

        for (int f = 0; f < 36; f++) begin
            k   = f % NDUT;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                d    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535))
                                                   : {1'($urandom_range(0, 1)), 15'($urandom_range(0, 2047))};
                last = (b == len - 1) && ((k != 2) || ($urandom_range(0, 1) != 0));
                send(k, d, last, 1'b1);
            end
            drain();
        end

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
